// File: rtl/alu_arbiter_if.sv
// Bundle between the two ALU requesters, the shared ALU, the result consumer and the arbiter.
// slave is the arbiter's view; master is everything around it.
interface alu_arbiter_if #(
    parameter int WIDTH = 64
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [1:0]       req0_ctrl;
    logic             req0_set_cc;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [1:0]       req1_ctrl;
    logic             req1_set_cc;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_control;
    logic [WIDTH-1:0] alu_ans;
    logic             alu_overflow;
    logic             alu_zf;
    logic             alu_sf;
    logic             alu_of;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_overflow;

    logic             cc_zf;
    logic             cc_sf;
    logic             cc_of;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl, req0_set_cc,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_ctrl, req1_set_cc,
        output req1_ready,
        output alu_a, alu_b, alu_control,
        input  alu_ans, alu_overflow, alu_zf, alu_sf, alu_of,
        output rsp_valid, rsp_id, rsp_data, rsp_overflow,
        input  rsp_ready,
        output cc_zf, cc_sf, cc_of
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl, req0_set_cc,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_ctrl, req1_set_cc,
        input  req1_ready,
        input  alu_a, alu_b, alu_control,
        output alu_ans, alu_overflow, alu_zf, alu_sf, alu_of,
        input  rsp_valid, rsp_id, rsp_data, rsp_overflow,
        output rsp_ready,
        input  cc_zf, cc_sf, cc_of
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters; result registered into a
// one-entry slot (latency 1). A full, unconsumed slot drops both readys; the CC register lives here.
module alu_arbiter #(
    parameter int WIDTH = 64
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    logic             any_valid;
    logic             grant;
    logic             slot_free;
    logic             accept;
    logic             sel_set_cc;
    logic             last_grant;

    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_overflow_q;
    logic             cc_zf_q;
    logic             cc_sf_q;
    logic             cc_of_q;

    // grant is only meaningful while any_valid; a lone requester always wins.
    always_comb begin
        any_valid  = bus.req0_valid | bus.req1_valid;
        grant      = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
        slot_free  = ~rsp_valid_q | bus.rsp_ready;
        accept     = any_valid & slot_free;
        sel_set_cc = grant ? bus.req1_set_cc : bus.req0_set_cc;
    end

    assign bus.req0_ready  = accept & ~grant;
    assign bus.req1_ready  = accept & grant;

    assign bus.alu_a       = !any_valid ? '0    : (grant ? bus.req1_a    : bus.req0_a);
    assign bus.alu_b       = !any_valid ? '0    : (grant ? bus.req1_b    : bus.req0_b);
    assign bus.alu_control = !any_valid ? 2'b00 : (grant ? bus.req1_ctrl : bus.req0_ctrl);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_data_q     <= '0;
            rsp_overflow_q <= 1'b0;
            cc_zf_q        <= 1'b1;
            cc_sf_q        <= 1'b0;
            cc_of_q        <= 1'b0;
            last_grant     <= 1'b1;
        end else if (accept) begin
            rsp_valid_q    <= 1'b1;
            rsp_id_q       <= grant;
            rsp_data_q     <= bus.alu_ans;
            rsp_overflow_q <= bus.alu_overflow;
            last_grant     <= grant;
            if (sel_set_cc) begin
                cc_zf_q <= bus.alu_zf;
                cc_sf_q <= bus.alu_sf;
                cc_of_q <= bus.alu_of;
            end
        end else if (bus.rsp_ready) begin
            // Drain only; payload registers keep their last value.
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign bus.cc_zf        = cc_zf_q;
    assign bus.cc_sf        = cc_sf_q;
    assign bus.cc_of        = cc_of_q;
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational execute-stage ALU between two requesters, e.g. the main execute path and an address/auxiliary path.
- Arbitrates round-robin with valid/ready handshakes and registers each ALU result into a one-entry output slot (latency 1).
- Owns the architectural condition-code register (ZF/SF/OF); it updates the register only for operations that request it.

Parameters:
- WIDTH, 64, operand/result width; must match the ALU datapath width.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  WIDTH  operand a.
- req0_b  input  WIDTH  operand b.
- req0_ctrl  input  2  ALU op: 00 add, 01 sub (a-b), 10 and, 11 xor.
- req0_set_cc  input  1  update the CC register from this op.
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl, req1_set_cc: same as requester 0.
- alu_a  output  WIDTH  operand a driven to the ALU.
- alu_b  output  WIDTH  operand b driven to the ALU.
- alu_control  output  2  op driven to the ALU.
- alu_ans  input  WIDTH  ALU result.
- alu_overflow  input  1  ALU overflow.
- alu_zf, alu_sf, alu_of  input  1  ALU flag outputs.
- rsp_valid  output  1  result slot full.
- rsp_ready  input  1  consumer takes the result.
- rsp_id  output  1  requester that owns rsp_data.
- rsp_data  output  WIDTH  registered result.
- rsp_overflow  output  1  registered overflow.
- cc_zf, cc_sf, cc_of  output  1  condition-code register.

Behaviour:
- Clock and reset: single clock domain (clk). rst_n is asynchronous and active-low.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_overflow=0.
  - cc_zf=1, cc_sf=0, cc_of=0.
  - last_grant=1, so requester 0 wins the first tie.
- slot_free = !rsp_valid || rsp_ready (combinational).
- Grant (combinational, evaluated every cycle):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester other than last_grant is granted.
  - No requester valid: no grant.
- reqN_ready = slot_free && grant==N. At most one ready is high per cycle. Ready may depend on valid. Requesters hold their valid and operands stable until ready.
- ALU drive:
  - Granted requester: its a/b/ctrl are muxed onto alu_a/alu_b/alu_control.
  - No grant: the ALU is driven with 0/0/00.
- Accept (reqN_valid && reqN_ready) at a rising edge:
  - rsp_data<=alu_ans, rsp_overflow<=alu_overflow, rsp_id<=N, rsp_valid<=1, last_grant<=N.
  - If reqN_set_cc: cc_zf/cc_sf/cc_of <= alu_zf/alu_sf/alu_of on the same edge. Otherwise the CC register holds.
- Latency: the result is visible one cycle after the accept edge.
- Throughput: 1 op/cycle while rsp_ready=1. Accept and drain in the same cycle are legal: the slot is overwritten with the new result and rsp_valid stays 1.
- Drain without accept: rsp_valid && rsp_ready with no new accept -> rsp_valid<=0. The data registers hold their last value.
- Backpressure: rsp_valid && !rsp_ready -> slot and outputs hold, both readys are 0, last_grant is unchanged.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1. No requester waits more than one accept.
- Reset mid-operation: the in-flight result is discarded and every register returns to its reset value immediately (asynchronous). Pending requests are re-arbitrated from the reset state after rst_n deasserts.
- Width rules:
  - All arithmetic is performed by the ALU at WIDTH bits; the arbiter adds no arithmetic.
  - Overflow and flags are passed through unmodified.
  - and/xor ops report overflow=0, as the ALU supplies it.

Test Plan:
- Reset, then req0 add a=5, b=7, set_cc=1, rsp_ready=1 -> req0_ready=1 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=12, cc_zf=0, cc_sf=0, cc_of=0.
- req1 add a=0x7FFF_FFFF_FFFF_FFFF, b=1, set_cc=1 -> rsp_data=0x8000_0000_0000_0000, rsp_overflow=1, cc_of=1, cc_sf=1, cc_zf=0.
- After reset, both valid with continuous requests (req0 sub 9-9, req1 xor 0xF0^0x0F) and rsp_ready=1:
  - Accepts occur in the order 0,1,0,1.
  - Results: id0 data 0 (cc_zf=1 if set_cc), id1 data 0xFF.
- Backpressure: rsp_ready=0 with a result held and req0 valid -> req0_ready=0 and rsp_data stable for 3 cycles. When rsp_ready rises, the held result drains and req0 is accepted in that same cycle.
- req0 and a=0xFF, b=0x0F, set_cc=0 after cc_zf=1 -> rsp_data=0x0F and CC unchanged (cc_zf=1).
- Assert rst_n=0 mid-cycle while rsp_valid=1 -> rsp_valid=0, cc_zf=1 immediately without waiting for a clock edge. After release, dual requests grant requester 0 first.
